// File: rtl/biquad_seq_pkg.sv
// Shared types and constants for the biquad_seq cascade.
// Holds the FSM encoding, datapath widths and the 16-bit saturator.
package biquad_seq_pkg;

    localparam int SAMPLE_W = 16;
    localparam int COEF_W   = 10;
    localparam int ACC_W    = 18;
    localparam int ADDR_W   = 4;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        M1_REQ,
        M1_WAIT,
        M2_REQ,
        M2_WAIT,
        ACC,
        OUT
    } state_t;

    // Clamp the wide accumulator into the 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(
        input logic signed [ACC_W-1:0] a
    );
        if (a > SAT_MAX) return SAT_MAX[SAMPLE_W-1:0];
        if (a < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
        return a[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/biquad_seq_coef_rf.sv
// Coefficient register file: one write port, one combinational read port.
// Out-of-range writes are dropped; a same-cycle read sees the old value.
module biquad_coef_rf
    import biquad_seq_pkg::*;
#(
    parameter int DEPTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COEF_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COEF_W-1:0] rdata
);

    logic [COEF_W-1:0] mem [DEPTH];

    // Clear on reset, otherwise store in-range writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && int'(waddr) < DEPTH) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/biquad_seq.sv
// Sequenced cascade of two-pole sections sharing one external multiplier.
// Each section issues a1*y1 then a2*y2, accumulates and saturates.
module biquad_seq
    import biquad_seq_pkg::*;
#(
    parameter int NSECT = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_stb,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       out_stb,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       coef_we,
    input  logic [ADDR_W-1:0]          coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic signed [SAMPLE_W-1:0] mul_sig,
    output logic [COEF_W-1:0]          mul_coef,
    output logic                       mul_start,
    input  logic signed [SAMPLE_W-1:0] mul_result,
    input  logic                       mul_done
);

    localparam int SW = (NSECT > 1) ? $clog2(NSECT) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSECT - 1);

    state_t                     state;
    logic [SW-1:0]              sect;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] y1 [NSECT];
    logic signed [SAMPLE_W-1:0] y2 [NSECT];
    logic [ADDR_W-1:0]          rd_addr;
    logic [COEF_W-1:0]          rd_coef;
    logic signed [SAMPLE_W-1:0] y_sat;

    assign y_sat = sat16(acc);

    biquad_coef_rf #(
        .DEPTH (2 * NSECT)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (coef_we),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (rd_addr),
        .rdata (rd_coef)
    );

    // Address the coefficient that the next REQ state will latch.
    always_comb begin
        rd_addr = '0;
        case (state)
            M1_WAIT: rd_addr = ADDR_W'({sect, 1'b1});
            ACC:     rd_addr = ADDR_W'({sect + SW'(1), 1'b0});
            default: rd_addr = '0;
        endcase
    end

    // Sequencer: operands latched on entry to REQ and held until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sect       <= '0;
            acc        <= '0;
            sample_out <= '0;
            out_stb    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            mul_start  <= 1'b0;
            mul_sig    <= '0;
            mul_coef   <= '0;
            for (int i = 0; i < NSECT; i++) begin
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            out_stb   <= 1'b0;
            mul_start <= 1'b0;
            if (sample_stb && state != IDLE) overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (sample_stb) begin
                        acc       <= ACC_W'(sample_in);
                        sect      <= '0;
                        busy      <= 1'b1;
                        mul_start <= 1'b1;
                        mul_sig   <= y1[0];
                        mul_coef  <= rd_coef;
                        state     <= M1_REQ;
                    end
                end
                M1_REQ: state <= M1_WAIT;
                M1_WAIT: begin
                    if (mul_done) begin
                        acc       <= acc + ACC_W'(mul_result);
                        mul_start <= 1'b1;
                        mul_sig   <= y2[sect];
                        mul_coef  <= rd_coef;
                        state     <= M2_REQ;
                    end
                end
                M2_REQ: state <= M2_WAIT;
                M2_WAIT: begin
                    if (mul_done) begin
                        acc   <= acc + ACC_W'(mul_result);
                        state <= ACC;
                    end
                end
                ACC: begin
                    y2[sect] <= y1[sect];
                    y1[sect] <= y_sat;
                    if (sect == LAST) begin
                        sample_out <= y_sat;
                        out_stb    <= 1'b1;
                        state      <= OUT;
                    end else begin
                        sect      <= sect + SW'(1);
                        acc       <= ACC_W'(y_sat);
                        mul_start <= 1'b1;
                        mul_sig   <= y1[sect + SW'(1)];
                        mul_coef  <= rd_coef;
                        state     <= M1_REQ;
                    end
                end
                OUT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_seq.sv
// Directed bench for biquad_seq with a behavioural sign-magnitude
// multiplier that answers each request after a fixed or random delay.
module tb_biquad_seq;
    import biquad_seq_pkg::*;

    localparam int NSECT = 6;
    // Cycles counted inclusive of the sample_stb and out_stb cycles.
    localparam int LAT1 = 1 + NSECT * (2 * (1 + 1) + 1) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [15:0]  sample_in;
    logic                sample_stb;
    logic signed [15:0]  sample_out;
    logic                out_stb;
    logic                busy;
    logic                overrun;
    logic                coef_we;
    logic [3:0]          coef_addr;
    logic [9:0]          coef_data;
    logic signed [15:0]  mul_sig;
    logic [9:0]          mul_coef;
    logic                mul_start;
    logic signed [15:0]  mul_result;
    logic                mul_done;

    int checks = 0;
    int errors = 0;

    int  mul_lat = 1;
    bit  rand_lat = 1'b0;
    int  starts = 0;
    int  outs = 0;
    int  stab_err = 0;
    int  overlap_err = 0;
    bit  pend = 1'b0;
    int  cnt = 0;
    logic signed [15:0] cap_sig;
    logic [9:0]         cap_coef;

    biquad_seq #(.NSECT(NSECT)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .sample_stb (sample_stb),
        .sample_out (sample_out),
        .out_stb    (out_stb),
        .busy       (busy),
        .overrun    (overrun),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .mul_sig    (mul_sig),
        .mul_coef   (mul_coef),
        .mul_start  (mul_start),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    function automatic int mulm(input int sig, input logic [9:0] c);
        int mag;
        int m;
        mag = (sig < 0) ? -sig : sig;
        m = (mag * int'(c[8:0])) >>> 9;
        return ((sig < 0) ^ c[9]) ? -m : m;
    endfunction

    function automatic int sat(input int a);
        if (a > 32767) return 32767;
        if (a < -32768) return -32768;
        return a;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Multiplier model and out_stb / handshake monitor.
    initial begin
        mul_done = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_done = 1'b0;
            if (out_stb === 1'b1) outs++;
            if (pend) begin
                if (mul_sig !== cap_sig || mul_coef !== cap_coef) stab_err++;
                if (cnt == 0) begin
                    mul_done = 1'b1;
                    mul_result = 16'(mulm(int'(cap_sig), cap_coef));
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mul_start === 1'b1) begin
                if (pend) overlap_err++;
                cap_sig = mul_sig;
                cap_coef = mul_coef;
                pend = 1'b1;
                starts++;
                cnt = rand_lat ? int'($urandom_range(40, 0)) : mul_lat - 1;
            end
        end
    end

    task automatic wr(input int a, input logic [9:0] d);
        coef_addr = 4'(a);
        coef_data = d;
        coef_we = 1'b1;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic send(input int s);
        sample_in = 16'(s);
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_out(output int edges, output logic signed [15:0] y);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (out_stb !== 1'b1 && edges < 5000);
        chk("out_seen", out_stb, 1);
        y = sample_out;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] ctab [12] = '{10'h0F0, 10'h280, 10'h333, 10'h040,
                              10'h1C0, 10'h2C0, 10'h000, 10'h3FF,
                              10'h100, 10'h100, 10'h2AA, 10'h155};
    int stim [6] = '{4000, -2500, 12000, 0, 32767, -32768};

    initial begin
        int e;
        int s0;
        int o0;
        int st0;
        int x;
        int a;
        int ym;
        int my1 [NSECT];
        int my2 [NSECT];
        logic signed [15:0] y;

        rst = 1'b1;
        sample_in = '0;
        sample_stb = 1'b0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample_out", sample_out, 0);
        chk("rst_out_stb", out_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_sig", mul_sig, 0);
        chk("rst_mul_coef", mul_coef, 0);
        rst = 1'b0;

        // Pass-through with zero coefficients.
        s0 = starts;
        send(1000);
        chk("pt_busy", busy, 1);
        wait_out(e, y);
        chk("pt_latency", e + 2, LAT1);
        chk("pt_value", y, 1000);
        chk("pt_mul_starts", starts - s0, 2 * NSECT);
        chk("pt_busy_after", busy, 0);
        chk("pt_stb_after", out_stb, 0);

        // Decay with a1[0] = +0.5; unused addresses must be ignored.
        do_reset();
        for (int i = 12; i < 16; i++) wr(i, 10'h1FF);
        wr(0, 10'h100);
        send(1000);
        wait_out(e, y);
        chk("decay0", y, 1000);
        send(0);
        wait_out(e, y);
        chk("decay1", y, 500);
        send(0);
        wait_out(e, y);
        chk("decay2", y, 250);
        chk("decay_no_overrun", overrun, 0);

        // Saturation, positive then negative.
        do_reset();
        wr(0, 10'h1FF);
        send(30000);
        wait_out(e, y);
        chk("satp0", y, 30000);
        send(30000);
        wait_out(e, y);
        chk("satp1", y, 32767);
        do_reset();
        wr(0, 10'h1FF);
        send(-30000);
        wait_out(e, y);
        chk("satn0", y, -30000);
        send(-30000);
        wait_out(e, y);
        chk("satn1", y, -32768);

        // Overrun: second strobe while busy is dropped.
        do_reset();
        o0 = outs;
        send(111);
        repeat (3) @(posedge clk);
        #1;
        send(222);
        chk("ovr_flag_set", overrun, 1);
        wait_out(e, y);
        chk("ovr_value", y, 111);
        repeat (40) @(posedge clk);
        #1;
        chk("ovr_one_out", outs - o0, 1);
        chk("ovr_sticky", overrun, 1);

        // Reset in M2_WAIT of section 3 with a slow multiplier.
        mul_lat = 20;
        s0 = starts;
        send(500);
        e = 0;
        while (starts - s0 < 8 && e < 2000) begin
            @(posedge clk);
            #2;
            e++;
        end
        chk("mid_starts", starts - s0, 8);
        @(posedge clk);
        #1;
        chk("mid_state_m2wait", dut.state, M2_WAIT);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        o0 = outs;
        chk("mid_sample_out", sample_out, 0);
        chk("mid_out_stb", out_stb, 0);
        chk("mid_busy", busy, 0);
        chk("mid_overrun", overrun, 0);
        chk("mid_mul_start", mul_start, 0);
        chk("mid_mul_sig", mul_sig, 0);
        chk("mid_mul_coef", mul_coef, 0);
        chk("mid_state_idle", dut.state, IDLE);
        e = 0;
        while (pend && e < 100) begin
            @(posedge clk);
            #1;
            e++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("mid_late_done_ignored", dut.state, IDLE);
        chk("mid_no_out", outs - o0, 0);
        chk("mid_busy_after", busy, 0);
        mul_lat = 1;
        send(1234);
        wait_out(e, y);
        chk("mid_next_pass", y, 1234);

        // Random multiplier stalls against a reference model.
        do_reset();
        rand_lat = 1'b1;
        st0 = stab_err;
        for (int i = 0; i < 2 * NSECT; i++) wr(i, ctab[i]);
        for (int k = 0; k < NSECT; k++) begin
            my1[k] = 0;
            my2[k] = 0;
        end
        for (int n = 0; n < 6; n++) begin
            x = stim[n];
            for (int k = 0; k < NSECT; k++) begin
                a = x + mulm(my1[k], ctab[2 * k]) + mulm(my2[k], ctab[2 * k + 1]);
                ym = sat(a);
                my2[k] = my1[k];
                my1[k] = ym;
                x = ym;
            end
            send(stim[n]);
            wait_out(e, y);
            chk($sformatf("stall_y%0d", n), y, x);
        end
        chk("stall_operands_stable", stab_err - st0, 0);
        chk("stall_no_overlap", overlap_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/biquad_seq.md
BIQUAD_SEQ -- requirements
Module: biquad_seq

Interface
REQ-001 SHALL have parameter NSECT, default 6, meaning the number of cascaded two-pole sections.
REQ-002 SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port sample_in, input, 16, signed excitation sample.
REQ-005 SHALL have port sample_stb, input, 1, one-cycle strobe qualifying sample_in.
REQ-006 SHALL have port sample_out, output, 16, signed filtered sample.
REQ-007 SHALL have port out_stb, output, 1, one-cycle strobe qualifying sample_out.
REQ-008 SHALL have port busy, output, 1, high while a sample is in process.
REQ-009 SHALL have port overrun, output, 1, sticky flag set when a sample is dropped.
REQ-010 SHALL have coefficient write port coef_we (input, 1), coef_addr (input, 4) and coef_data (input, 10, sign-magnitude).
REQ-011 SHALL have multiplier request ports mul_sig (output, 16, signed), mul_coef (output, 10, sign-magnitude) and mul_start (output, 1).
REQ-012 SHALL have multiplier return ports mul_result (input, 16, signed) and mul_done (input, 1), meaning mul_result is valid on mul_done.

Function
REQ-013 SHALL hold 2*NSECT coefficient registers; address 2k is a1 of section k and 2k+1 is a2; writes to addresses >= 2*NSECT SHALL be ignored.
REQ-014 SHALL interpret coefficients as sign (bit 9) plus magnitude/512 (bits 8:0), matching the multiplier: 32767 * 0x3FF gives -32703.
REQ-015 SHALL compute, per section k: y = sat16(x + a1*y1[k] + a2*y2[k]), then y2[k] <= y1[k], y1[k] <= y, and the next section's x = y.
REQ-016 SHALL use an 18-bit signed accumulator and saturate it to the range [-32768, 32767] once per section.
REQ-017 SHALL use the FSM states IDLE -> M1_REQ -> M1_WAIT -> M2_REQ -> M2_WAIT -> ACC -> (next section: M1_REQ | last section: OUT) -> IDLE.
REQ-018 SHALL pulse mul_start for exactly one cycle in each REQ state.
REQ-019 SHALL hold mul_sig and mul_coef stable from the REQ state until mul_done is sampled high.
REQ-020 SHALL, in M1, present y1[k] with a1; in M2, present y2[k] with a2.
REQ-021 SHALL add mul_result into the accumulator in the cycle mul_done is sampled high.
REQ-022 SHALL wait indefinitely in a WAIT state, with no timeout.
REQ-023 SHALL ignore mul_done outside the WAIT states.
REQ-024 SHALL accept sample_stb only in IDLE; busy SHALL be high from the cycle after acceptance until the cycle after out_stb.
REQ-025 SHALL, when sample_stb is high while busy, drop the sample and set overrun; overrun SHALL clear only on rst.
REQ-026 SHALL pulse out_stb for one cycle in OUT, with sample_out registered and held until the next OUT.
REQ-027 SHALL have latency = 1 + NSECT*(2*(1 + multiplier latency) + 1) + 1 cycles from sample_stb to out_stb.
REQ-028 SHALL accept coefficient writes in any state; a coefficient is read at its REQ state, so a mid-sample write affects only products not yet requested.
REQ-029 SHALL, when a write and a read of the same address occur in the same cycle, present the old value.

Reset
REQ-030 SHALL clear all coefficients, all y1/y2 histories, the accumulator, sample_out, out_stb, mul_start, mul_sig, mul_coef, busy and overrun to 0, and set state to IDLE.
REQ-031 SHALL, on rst mid-operation, abandon the sample with no out_stb; any later mul_done from the abandoned request SHALL be ignored.

Structure
REQ-032 SHALL place in the shared package: the FSM state enumeration, SAMPLE_W=16, COEF_W=10, ACC_W=18 and the sat16 limits.
REQ-033 SHALL contain one sub-module, biquad_coef_rf, the 2*NSECT x 10 coefficient register file with one write and one read port.
REQ-034 SHALL connect the multiplier externally and SHALL NOT instantiate it.

Verification
REQ-035 SHALL cover pass-through: all coefficients 0, sample_in=1000 -> sample_out=1000, out_stb at the computed latency, exactly 12 mul_start pulses.
REQ-036 SHALL cover decay: a1[0]=0x100 (+0.5), others 0; inputs 1000, 0, 0 -> outputs 1000, 500, 250.
REQ-037 SHALL cover saturation: a1[0]=0x1FF; inputs 30000, 30000 -> outputs 30000, 32767; negative mirror -30000, -30000 -> -30000, -32768.
REQ-038 SHALL cover overrun: second sample_stb while busy -> sample dropped, overrun=1, only one out_stb.
REQ-039 SHALL cover reset mid-operation: rst asserted in M2_WAIT of section 3 -> all outputs 0, state IDLE, a late mul_done ignored, next sample with zero coefficients passes unchanged.
REQ-040 SHALL cover handshake stall: multiplier model delaying mul_done by 0..40 random cycles -> mul_sig and mul_coef stable throughout, results bit-exact against a reference model.
